// File: rtl/oven_sequencer.sv
// Oven sequencer: holds the MM:SS setpoint, counts it down on the 1 Hz tick while cooking,
// drives the magnetron enable and gates keypad entry.
//
// state | meaning
// IDLE  | waiting for the first key, digits 00:00
// ENTRY | digits being keyed in
// COOK  | magnetron on, counting down
// PAUSE | stopped or door opened while cooking, digits retained
// DONE  | countdown reached 00:00, done flag held for DONE_HOLD ticks
module oven_sequencer #(
  parameter int unsigned DONE_HOLD = 3
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] BCD,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       keypad_en,
  output logic       mag_on,
  output logic       done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam logic [3:0] HOLD_INIT = 4'(DONE_HOLD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic [3:0] hold_q, hold_d;
  logic       loadn_q, startn_q, stopn_q, tick_q;

  logic       key_ev, start_ev, stop_ev, tick_ev;
  logic       zero;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       dec_zero;

  // Edge events are combinational against the previous sample, so they fire on first sight.
  assign key_ev   = loadn_q & ~loadn & (BCD <= 4'd9);
  assign start_ev = startn_q & ~startn;
  assign stop_ev  = stopn_q & ~stopn;
  assign tick_ev  = ~tick_q & pgt_1Hz;

  assign zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q  <= S_IDLE;
      mt_q     <= 4'd0;
      mo_q     <= 4'd0;
      st_q     <= 4'd0;
      so_q     <= 4'd0;
      hold_q   <= 4'd0;
      loadn_q  <= 1'b1;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mt_q     <= mt_d;
      mo_q     <= mo_d;
      st_q     <= st_d;
      so_q     <= so_d;
      hold_q   <= hold_d;
      loadn_q  <= loadn;
      startn_q <= startn;
      stopn_q  <= stopn;
      tick_q   <= pgt_1Hz;
    end
  end

  // One-second decrement; seconds borrow reloads 59, minutes borrow is plain BCD.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q;
    if (so_q != 4'd0) begin
      dec_so = so_q - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (st_q != 4'd0) begin
        dec_st = st_q - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (mo_q != 4'd0) begin
          dec_mo = mo_q - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = mt_q - 4'd1;
        end
      end
    end
    dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) && (dec_st == 4'd0) && (dec_so == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    hold_d  = hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (key_ev) begin
          mt_d    = mo_q;
          mo_d    = st_q;
          st_d    = so_q;
          so_d    = BCD;
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (stop_ev) begin
          mt_d    = 4'd0;
          mo_d    = 4'd0;
          st_d    = 4'd0;
          so_d    = 4'd0;
          state_d = S_IDLE;
        end else if (start_ev && zero) begin
          state_d = S_IDLE;
        end else if (start_ev && door_closed) begin
          state_d = S_COOK;
        end else if (key_ev) begin
          mt_d = mo_q;
          mo_d = st_q;
          st_d = so_q;
          so_d = BCD;
        end
      end

      S_COOK: begin
        if (stop_ev || !door_closed) begin
          state_d = S_PAUSE;
        end else if (tick_ev && !zero) begin
          mt_d = dec_mt;
          mo_d = dec_mo;
          st_d = dec_st;
          so_d = dec_so;
          if (dec_zero) begin
            hold_d  = HOLD_INIT;
            state_d = S_DONE;
          end
        end else if (zero) begin
          hold_d  = HOLD_INIT;
          state_d = S_DONE;
        end
      end

      S_PAUSE: begin
        if (stop_ev) begin
          mt_d    = 4'd0;
          mo_d    = 4'd0;
          st_d    = 4'd0;
          so_d    = 4'd0;
          state_d = S_IDLE;
        end else if (start_ev && door_closed) begin
          state_d = S_COOK;
        end
      end

      S_DONE: begin
        mt_d = 4'd0;
        mo_d = 4'd0;
        st_d = 4'd0;
        so_d = 4'd0;
        if (key_ev || start_ev || stop_ev) begin
          state_d = S_IDLE;
        end else if (tick_ev) begin
          if (hold_q <= 4'd1) begin
            hold_d  = 4'd0;
            state_d = S_IDLE;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end

      default: begin
        mt_d    = 4'd0;
        mo_d    = 4'd0;
        st_d    = 4'd0;
        so_d    = 4'd0;
        hold_d  = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign keypad_en = (state_q == S_IDLE) || (state_q == S_ENTRY);
  assign mag_on    = (state_q == S_COOK);
  assign done      = (state_q == S_DONE);
  assign min_tens  = mt_q;
  assign min_ones  = mo_q;
  assign sec_tens  = st_q;
  assign sec_ones  = so_q;

endmodule

// File: tb/tb_oven_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run,
// all compared every cycle against a minutes/seconds reference model.
module tb_oven_sequencer;
  localparam int DONE_HOLD = 3;

  logic       clock = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] BCD = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1Hz = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       door_closed = 1'b1;
  logic       keypad_en, mag_on, done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

  oven_sequencer #(.DONE_HOLD(DONE_HOLD)) dut (
    .clock(clock), .clearn(clearn), .BCD(BCD), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .startn(startn), .stopn(stopn), .door_closed(door_closed),
    .keypad_en(keypad_en), .mag_on(mag_on), .done(done),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode plus four display digits; countdown done on minute/second values.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;
  int m_mode = M_IDLE;
  int dig[4] = '{0, 0, 0, 0};
  int hold = 0;
  bit p_load = 1'b1, p_start = 1'b1, p_stop = 1'b1, p_tick = 1'b0;
  bit e_key, e_start, e_stop, e_tick;

  function automatic bit m_zero();
    return (dig[0] + dig[1] + dig[2] + dig[3]) == 0;
  endfunction

  task automatic m_tick_down();
    int m, s;
    m = dig[0] * 10 + dig[1];
    s = dig[2] * 10 + dig[3];
    if (s > 0) s--;
    else if (m > 0) begin m--; s = 59; end
    dig = '{m / 10, m % 10, s / 10, s % 10};
  endtask

  task automatic model_step();
    if (!clearn) begin
      m_mode = M_IDLE; dig = '{0, 0, 0, 0}; hold = 0;
      p_load = 1'b1; p_start = 1'b1; p_stop = 1'b1; p_tick = 1'b0;
      return;
    end
    e_key   = p_load && !loadn && (BCD <= 4'd9);
    e_start = p_start && !startn;
    e_stop  = p_stop && !stopn;
    e_tick  = !p_tick && pgt_1Hz;
    p_load = loadn; p_start = startn; p_stop = stopn; p_tick = pgt_1Hz;
    case (m_mode)
      M_IDLE: if (e_key) begin dig = '{dig[1], dig[2], dig[3], int'(BCD)}; m_mode = M_ENTRY; end
      M_ENTRY: begin
        if (e_stop) begin dig = '{0, 0, 0, 0}; m_mode = M_IDLE; end
        else if (e_start && m_zero()) m_mode = M_IDLE;
        else if (e_start && door_closed) m_mode = M_COOK;
        else if (e_key) dig = '{dig[1], dig[2], dig[3], int'(BCD)};
      end
      M_COOK: begin
        if (e_stop || !door_closed) m_mode = M_PAUSE;
        else if (e_tick) begin
          m_tick_down();
          if (m_zero()) begin m_mode = M_DONE; hold = DONE_HOLD; end
        end
      end
      M_PAUSE: begin
        if (e_stop) begin dig = '{0, 0, 0, 0}; m_mode = M_IDLE; end
        else if (e_start && door_closed) m_mode = M_COOK;
      end
      default: begin
        if (e_key || e_start || e_stop) m_mode = M_IDLE;
        else if (e_tick) begin
          hold--;
          if (hold == 0) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  always @(posedge clock or negedge clearn) model_step();

  always @(negedge clock) begin
    if (chk_en) begin
      chk("keypad_en", 32'(keypad_en), 32'(m_mode == M_IDLE || m_mode == M_ENTRY));
      chk("mag_on", 32'(mag_on), 32'(m_mode == M_COOK));
      chk("done", 32'(done), 32'(m_mode == M_DONE));
      chk("digits", 32'({min_tens, min_ones, sec_tens, sec_ones}),
          32'({4'(dig[0]), 4'(dig[1]), 4'(dig[2]), 4'(dig[3])}));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic key(input int d);
    BCD = 4'(d); loadn = 1'b0; cyc();
    loadn = 1'b1; cyc();
  endtask

  task automatic press_start();
    startn = 1'b0; cyc();
    startn = 1'b1; cyc();
  endtask

  task automatic press_stop();
    stopn = 1'b0; cyc();
    stopn = 1'b1; cyc();
  endtask

  task automatic tick();
    pgt_1Hz = 1'b1; cyc();
    pgt_1Hz = 1'b0; cyc();
  endtask

  function automatic logic [15:0] shown();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    cyc(2);
    chk("reset_keypad_en", 32'(keypad_en), 32'd1);
    chk("reset_mag_on", 32'(mag_on), 32'd0);
    chk("reset_digits", 32'(shown()), 32'h0000);
    clearn = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Key entry
    key(1); key(3); key(0);
    chk("entry_digits", 32'(shown()), 32'h0130);
    chk("entry_keypad_en", 32'(keypad_en), 32'd1);
    chk("entry_mag_on", 32'(mag_on), 32'd0);
    press_stop();
    chk("entry_stop_clear", 32'(shown()), 32'h0000);

    // Short cook to completion and done hold
    key(3);
    press_start();
    chk("cook_mag_on", 32'(mag_on), 32'd1);
    tick(); chk("cook_t1", 32'(shown()), 32'h0002);
    tick(); chk("cook_t2", 32'(shown()), 32'h0001);
    tick(); chk("cook_t3", 32'(shown()), 32'h0000);
    chk("done_flag", 32'(done), 32'd1);
    chk("done_mag_off", 32'(mag_on), 32'd0);
    tick(); tick();
    chk("done_still_held", 32'(done), 32'd1);
    tick();
    chk("done_released", 32'(done), 32'd0);
    chk("done_back_idle", 32'(keypad_en), 32'd1);

    // Borrow cases
    key(1); key(0); key(0);
    press_start(); tick();
    chk("borrow_0100", 32'(shown()), 32'h0059);
    press_stop(); press_stop();
    key(1); key(0); key(0); key(0);
    press_start(); tick();
    chk("borrow_1000", 32'(shown()), 32'h0959);
    press_stop(); press_stop();

    // Door opens on a tick cycle
    key(4); key(5);
    press_start();
    door_closed = 1'b0; pgt_1Hz = 1'b1; cyc();
    pgt_1Hz = 1'b0; door_closed = 1'b1; cyc();
    chk("pause_digits", 32'(shown()), 32'h0045);
    chk("pause_mag_off", 32'(mag_on), 32'd0);
    press_start();
    chk("resume_mag_on", 32'(mag_on), 32'd1);
    chk("resume_digits", 32'(shown()), 32'h0045);
    tick();
    chk("resume_tick", 32'(shown()), 32'h0044);
    press_stop(); press_stop();
    chk("pause_stop_clear", 32'(shown()), 32'h0000);
    chk("pause_stop_idle", 32'(keypad_en), 32'd1);

    // Start with door open is ignored; start with zero returns idle
    key(5);
    door_closed = 1'b0; cyc();
    press_start();
    chk("door_open_start", 32'(mag_on), 32'd0);
    chk("door_open_entry", 32'(keypad_en), 32'd1);
    door_closed = 1'b1; cyc();
    press_start();
    chk("door_closed_start", 32'(mag_on), 32'd1);
    press_stop(); press_stop();
    key(0);
    press_start();
    chk("zero_start_mag", 32'(mag_on), 32'd0);
    chk("zero_start_idle", 32'(keypad_en), 32'd1);

    // Held start produces one event
    key(1); key(5);
    startn = 1'b0; cyc();
    repeat (10) tick();
    chk("held_start_digits", 32'(shown()), 32'h0005);
    chk("held_start_cook", 32'(mag_on), 32'd1);
    stopn = 1'b0; cyc(); stopn = 1'b1; cyc(3);
    chk("held_start_paused", 32'(mag_on), 32'd0);
    startn = 1'b1; cyc();
    press_start();
    chk("restart_cook", 32'(mag_on), 32'd1);

    // Async reset mid-cook
    @(posedge clock); #2;
    clearn = 1'b0; #1;
    chk("async_mag_off", 32'(mag_on), 32'd0);
    chk("async_digits", 32'(shown()), 32'h0000);
    cyc();
    clearn = 1'b1; cyc();

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 35) begin
        if (loadn) BCD = 4'($urandom_range(0, 11));
        loadn = ~loadn;
      end
      if ($urandom_range(0, 99) < 12) startn = ~startn;
      if (stopn) begin if ($urandom_range(0, 99) < 2) stopn = 1'b0; end
      else if ($urandom_range(0, 99) < 50) stopn = 1'b1;
      if ($urandom_range(0, 99) < 25) pgt_1Hz = ~pgt_1Hz;
      if (door_closed) begin if ($urandom_range(0, 99) < 2) door_closed = 1'b0; end
      else if ($urandom_range(0, 99) < 30) door_closed = 1'b1;
      cyc();
    end

    loadn = 1'b1; startn = 1'b1; stopn = 1'b1; pgt_1Hz = 1'b0; door_closed = 1'b1;
    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
